// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding memory-stage initiator for the data RAM.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned H/W accesses into byte ops; otherwise they fault.
package lsu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;
endpackage

module load_store_unit
  import lsu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_w_data,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_fault,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_w_data,
  output write_width_t    mem_w_width,
  output logic            mem_w_enable,
  input  logic [XLEN-1:0] mem_r_data
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      last_idx_q, last_idx_d;
  logic            store_q, store_d;
  logic            split_q, split_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_fault_q, resp_fault_d;
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_w_data_q, mem_w_data_d;
  write_width_t    mem_w_width_q, mem_w_width_d;
  logic            mem_w_enable_q, mem_w_enable_d;

  logic            aligned, illegal;
  logic [XLEN-1:0] raw;

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] v);
    case (f3)
      3'b000:  return {{(XLEN-8){v[7]}}, v[7:0]};
      3'b001:  return {{(XLEN-16){v[15]}}, v[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, v[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    last_idx_d     = last_idx_q;
    store_d        = store_q;
    split_d        = split_q;
    funct3_d       = funct3_q;
    wdata_d        = wdata_q;
    acc_d          = acc_q;
    resp_valid_d   = 1'b0;
    resp_fault_d   = 1'b0;
    resp_data_d    = '0;
    mem_addr_d     = mem_addr_q;
    mem_w_data_d   = mem_w_data_q;
    mem_w_width_d  = mem_w_width_q;
    mem_w_enable_d = mem_w_enable_q;
    raw            = mem_r_data;

    aligned = (req_funct3[1:0] == 2'b00) ||
              (req_funct3[1:0] == 2'b01 && !req_addr[0]) ||
              (req_funct3[1:0] == 2'b10 && req_addr[1:0] == 2'b00);
    illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
              (req_store && req_funct3[2]);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal || (!aligned && !SPLIT_EN)) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d        = ISSUE;
            store_d        = req_store;
            funct3_d       = req_funct3;
            wdata_d        = req_w_data;
            split_d        = !aligned;
            idx_d          = 2'd0;
            acc_d          = '0;
            mem_addr_d     = req_addr;
            mem_w_enable_d = req_store;
            if (aligned) begin
              last_idx_d = 2'd0;
              case (req_funct3[1:0])
                2'b00: begin
                  mem_w_width_d = write_byte;
                  mem_w_data_d  = {{(XLEN-8){1'b0}}, req_w_data[7:0]};
                end
                2'b01: begin
                  mem_w_width_d = write_halfword;
                  mem_w_data_d  = {{(XLEN-16){1'b0}}, req_w_data[15:0]};
                end
                default: begin
                  mem_w_width_d = write_word;
                  mem_w_data_d  = req_w_data;
                end
              endcase
            end else begin
              last_idx_d    = (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;
              mem_w_width_d = write_byte;
              mem_w_data_d  = {{(XLEN-8){1'b0}}, req_w_data[7:0]};
            end
          end
        end
      end
      ISSUE: begin
        // read data for the previous byte op arrives one cycle after its address
        if (idx_q != 2'd0)
          acc_d[{idx_q - 2'd1, 3'b000} +: 8] = mem_r_data[7:0];
        if (idx_q == last_idx_q) begin
          mem_w_enable_d = 1'b0;
          if (store_q) begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          idx_d        = idx_q + 2'd1;
          mem_addr_d   = mem_addr_q + XLEN'(1);
          mem_w_data_d = {{(XLEN-8){1'b0}}, wdata_q[{idx_q + 2'd1, 3'b000} +: 8]};
        end
      end
      DRAIN: begin
        if (split_q) begin
          raw = acc_q;
          raw[{last_idx_q, 3'b000} +: 8] = mem_r_data[7:0];
        end
        resp_data_d  = extend(funct3_q, raw);
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      last_idx_q     <= 2'd0;
      store_q        <= 1'b0;
      split_q        <= 1'b0;
      funct3_q       <= 3'b000;
      wdata_q        <= '0;
      acc_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_fault_q   <= 1'b0;
      resp_data_q    <= '0;
      mem_addr_q     <= '0;
      mem_w_data_q   <= '0;
      mem_w_width_q  <= write_word;
      mem_w_enable_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      last_idx_q     <= last_idx_d;
      store_q        <= store_d;
      split_q        <= split_d;
      funct3_q       <= funct3_d;
      wdata_q        <= wdata_d;
      acc_q          <= acc_d;
      resp_valid_q   <= resp_valid_d;
      resp_fault_q   <= resp_fault_d;
      resp_data_q    <= resp_data_d;
      mem_addr_q     <= mem_addr_d;
      mem_w_data_q   <= mem_w_data_d;
      mem_w_width_q  <= mem_w_width_d;
      mem_w_enable_q <= mem_w_enable_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_fault   = resp_fault_q;
  assign resp_data    = resp_data_q;
  assign mem_addr     = mem_addr_q;
  assign mem_w_data   = mem_w_data_q;
  assign mem_w_width  = mem_w_width_q;
  assign mem_w_enable = mem_w_enable_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level golden memory model, per-cycle compare, directed vectors.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         req_valid = 1'b0, req_store = 1'b0;
  logic [2:0]   req_funct3 = 3'b000;
  logic [31:0]  req_addr = 32'h0, req_w_data = 32'h0;
  logic         req_ready, resp_valid, resp_fault, mem_w_enable;
  logic [31:0]  resp_data, mem_addr, mem_w_data;
  logic [31:0]  mem_r_data = 32'h0;
  write_width_t mem_w_width;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_w_data(req_w_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_width(mem_w_width),
    .mem_w_enable(mem_w_enable), .mem_r_data(mem_r_data)
  );

  // RAM the DUT talks to (1 KiB window, address bits above 9 ignored)
  logic [7:0]  ram  [0:1023] = '{default: 8'h00};
  logic [7:0]  gold [0:1023] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr = 32'h0, pl_word = 32'h0;

  always @(posedge clock) begin : ram_p
    logic [9:0] ra;
    ra = mem_addr[9:0];
    mem_r_data <= {ram[ra + 10'd3], ram[ra + 10'd2], ram[ra + 10'd1], ram[ra]};
    if (pl_en) begin
      for (int k = 0; k < 4; k++) ram[pl_addr[9:0] + 10'(k)] <= pl_word[8*k +: 8];
    end else if (mem_w_enable) begin
      ram[ra] <= mem_w_data[7:0];
      if (mem_w_width != write_byte) ram[ra + 10'd1] <= mem_w_data[15:8];
      if (mem_w_width == write_word) begin
        ram[ra + 10'd2] <= mem_w_data[23:16];
        ram[ra + 10'd3] <= mem_w_data[31:24];
      end
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic fault; logic [31:0] data; } rsp_t;
  typedef struct { int cyc; logic [31:0] addr; write_width_t width; logic [31:0] data; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  int n_cmp = 0, n_fail = 0;
  int acc_last = 0, ready_from = 0, tgt = 0;
  logic chk_en = 1'b0;
  logic [31:0] last_data = 32'h0;
  logic        last_fault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Load result from the golden byte memory: little-endian gather, then sign/zero extend
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v, ad;
    n = nbytes(f3);
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      ad = a + 32'(k);
      v = v | (32'(gold[ad[9:0]]) << (8*k));
    end
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!(cyc > acc_last && cyc < ready_from)));
      if (rq.size() != 0 && rq[0].cyc == cyc) begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_fault", 32'(resp_fault), 32'(rq[0].fault));
        chk("resp_data", resp_data, rq[0].data);
        last_data  = resp_data;
        last_fault = resp_fault;
        void'(rq.pop_front());
      end else begin
        chk("resp_valid quiet", 32'(resp_valid), 32'd0);
      end
      if (wq.size() != 0 && wq[0].cyc == cyc) begin
        logic [31:0] m;
        m = (wq[0].width == write_byte) ? 32'h0000_00FF :
            (wq[0].width == write_halfword) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        chk("mem_w_enable", 32'(mem_w_enable), 32'd1);
        chk("mem_addr", mem_addr, wq[0].addr);
        chk("mem_w_width", 32'(mem_w_width), 32'(wq[0].width));
        chk("mem_w_data", mem_w_data & m, wq[0].data & m);
        void'(wq.pop_front());
      end else begin
        chk("mem_w_enable quiet", 32'(mem_w_enable), 32'd0);
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) gold[a[9:0] + 10'(k)] = w[8*k +: 8];
    pl_addr = a;
    pl_word = w;
    pl_en   = 1'b1;
    @(posedge clock);
    #1 pl_en = 1'b0;
  endtask

  task automatic issue_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    int n, ops, lat, c;
    logic bad, mis, flt;
    logic [31:0] ad;
    rsp_t r;
    n   = nbytes(f3);
    bad = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (st && f3[2]);
    mis = (int'(a[1:0]) % n) != 0;
    flt = bad || (mis && !SPLIT);
    c   = cyc;
    if (flt) begin
      lat = 1;
      r = '{c + 1, 1'b1, 32'h0};
    end else begin
      ops = mis ? n : 1;
      lat = st ? ops + 1 : ops + 2;
      if (st) begin
        for (int k = 0; k < n; k++) begin
          ad = a + 32'(k);
          gold[ad[9:0]] = wd[8*k +: 8];
          if (mis) wq.push_back('{c + 1 + k, ad, write_byte, 32'(wd[8*k +: 8])});
        end
        if (!mis)
          wq.push_back('{c + 1, a, (n == 1) ? write_byte : (n == 2) ? write_halfword : write_word, wd});
        r = '{c + lat, 1'b0, 32'h0};
      end else begin
        r = '{c + lat, 1'b0, model_load(f3, a)};
      end
    end
    rq.push_back(r);
    acc_last   = c;
    ready_from = c + lat;
    tgt        = c + lat;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_w_data = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // Returns at negedge+1 of the response cycle, so the next request is back-to-back
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    issue_req(st, f3, a, wd);
    do @(negedge clock); while (cyc < tgt);
    #1;
  endtask

  task automatic expect_last(input string name, input logic [31:0] d, input logic f);
    chk({name, " data"}, last_data, d);
    chk({name, " fault"}, 32'(last_fault), 32'(f));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_fault", 32'(resp_fault), 32'd0);
    chk("reset resp_data", resp_data, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_w_data", mem_w_data, 32'h0);
    chk("reset mem_w_width", 32'(mem_w_width), 32'(write_word));
    chk("reset mem_w_enable", 32'(mem_w_enable), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    #1;
    acc_last = cyc; ready_from = cyc; chk_en = 1'b1;

    preload(32'h100, 32'h80FF_1234);
    preload(32'h200, 32'h5566_7788);
    preload(32'h3FC, 32'h9A00_0000);
    preload(32'h000, 32'h0000_00BC);

    do_req(1'b0, 3'b010, 32'h100, 32'h0); expect_last("LW 0x100",  32'h80FF_1234, 1'b0);
    do_req(1'b0, 3'b000, 32'h101, 32'h0); expect_last("LB 0x101",  32'h0000_0012, 1'b0);
    do_req(1'b0, 3'b100, 32'h101, 32'h0); expect_last("LBU 0x101", 32'h0000_0012, 1'b0);
    do_req(1'b0, 3'b000, 32'h103, 32'h0); expect_last("LB 0x103",  32'hFFFF_FF80, 1'b0);
    do_req(1'b0, 3'b100, 32'h103, 32'h0); expect_last("LBU 0x103", 32'h0000_0080, 1'b0);
    do_req(1'b0, 3'b001, 32'h102, 32'h0); expect_last("LH 0x102",  32'hFFFF_80FF, 1'b0);
    do_req(1'b0, 3'b101, 32'h102, 32'h0); expect_last("LHU 0x102", 32'h0000_80FF, 1'b0);

    do_req(1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
    do_req(1'b0, 3'b010, 32'h200, 32'h0); expect_last("LW after SH", 32'hABCD_7788, 1'b0);
    do_req(1'b1, 3'b000, 32'h201, 32'h1234_56EE);
    do_req(1'b0, 3'b010, 32'h200, 32'h0); expect_last("LW after SB", 32'hABCD_EE88, 1'b0);

    do_req(1'b0, 3'b011, 32'h100, 32'h0); expect_last("funct3 011", 32'h0, 1'b1);
    do_req(1'b0, 3'b110, 32'h100, 32'h0); expect_last("funct3 110", 32'h0, 1'b1);
    do_req(1'b1, 3'b100, 32'h100, 32'hFFFF_FFFF); expect_last("store funct3 100", 32'h0, 1'b1);

    do_req(1'b1, 3'b010, 32'h301, 32'h1122_3344);
    do_req(1'b0, 3'b010, 32'h301, 32'h0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    expect_last("split LW 0x301", 32'h1122_3344, 1'b0);
    do_req(1'b0, 3'b001, 32'h303, 32'h0); expect_last("split LH 0x303", 32'h0000_1122, 1'b0);
    do_req(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0); expect_last("split LH wrap", 32'hFFFF_BC9A, 1'b0);
`else
    expect_last("LW 0x301 fault", 32'h0, 1'b1);
    do_req(1'b0, 3'b001, 32'h303, 32'h0); expect_last("LH 0x303 fault", 32'h0, 1'b1);
    chk("SW 0x301 no write", 32'(ram[10'h301]), 32'h0);
`endif

    // reset in the second cycle of an operation
`ifdef LSU_MISALIGNED_SPLIT_EN
    issue_req(1'b1, 3'b010, 32'h401, 32'hA1B2_C3D4);
`else
    issue_req(1'b0, 3'b010, 32'h100, 32'h0);
`endif
    @(negedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    chk_en = 1'b0;
    #1;
    chk("async reset mem_w_enable", 32'(mem_w_enable), 32'd0);
    chk("async reset req_ready", 32'(req_ready), 32'd1);
    chk("async reset resp_valid", 32'(resp_valid), 32'd0);
    rq.delete();
    wq.delete();
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    for (int k = 2; k < 5; k++) gold[10'h400 + 10'(k)] = 8'h00;
    chk("partial store byte0", 32'(ram[10'h401]), 32'h0000_00D4);
    chk("partial store byte1", 32'(ram[10'h402]), 32'h0);
`endif
    acc_last = cyc; ready_from = cyc; chk_en = 1'b1;
    repeat (3) @(negedge clock);
    #1;
`ifdef LSU_MISALIGNED_SPLIT_EN
    do_req(1'b0, 3'b010, 32'h400, 32'h0); expect_last("LW after reset", 32'h0000_D400, 1'b0);
`else
    do_req(1'b0, 3'b010, 32'h100, 32'h0); expect_last("LW after reset", 32'h80FF_1234, 1'b0);
`endif
    repeat (2) @(negedge clock);
    #1;
    chk("resp queue drained", 32'(rq.size()), 32'd0);
    chk("write queue drained", 32'(wq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
